shared_bus_rr_arbiter: RTL and testbench
========================================

# shared_bus_rr_arbiter

Round-robin arbiter that shares one registered 8-bit output bus between several requesters, feeding the interface data field driven onto `o_a` at top level. Requesters hold a request and present beats. The arbiter grants one owner at a time, loads its beats into a one-entry output register under a valid/ready handshake, and rotates ownership fairly on packet end, on request drop, or on a hold limit.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `DATA_W`, default 8: beat width.
- `MAX_HOLD`, default 4: maximum beats per grant when the hold limit is compiled in; legal range 1..15.
- `i_clk`, input, 1: sole clock; all state updates on its rising edge.
- `i_rst_n`, input, 1: reset, asynchronous assert, active low.
- `i_req`, input, `N_REQ`: per-requester request; bit k high means requester k has a beat on its data slice.
- `i_data`, input, `N_REQ*DATA_W`: requester k beat on bits `[k*DATA_W +: DATA_W]`.
- `i_last`, input, `N_REQ`: marks requester k's current beat as the final beat of its packet.
- `o_gnt`, output, `N_REQ`: registered one-hot grant; all zero when idle.
- `i_ready`, input, 1: downstream accepts `o_a` when `o_valid & i_ready`.
- `o_valid`, output, 1: `o_a` holds an unconsumed beat.
- `o_a`, output, `DATA_W`: registered shared output beat.

## Operation
- Reset values: `o_gnt`=0, `o_valid`=0, `o_a`=0, FSM=IDLE, beat count=0, `last_owner`=`N_REQ-1`. The first grant after reset therefore goes to the lowest requesting index starting from 0.
- **IDLE:**
  - If `i_req` is nonzero, select the first requesting index scanning upward from `last_owner+1`, modulo `N_REQ`.
  - Set `o_gnt` to that index, clear the beat count, and go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY (owner = grant index):**
  - Accept condition: `i_req[owner] & (~o_valid | i_ready)`.
  - On accept: `o_a` <= owner's data slice, `o_valid` <= 1, beat count += 1 (4-bit counter, saturating at 15).
  - Release: leave for IDLE and set `o_gnt` <= 0 and `last_owner` <= owner when any of the following holds:
    - an accepted beat has `i_last[owner]`=1;
    - `i_req[owner]`=0 (drop, no beat taken);
    - an accepted beat brings the count to `MAX_HOLD` (hold limit only).
- Output register: when `o_valid & i_ready` and there is no accept in the same cycle, `o_valid` <= 0. `o_a` holds its value when not loaded.
- Data and `i_last` from non-owners are ignored. Requests from non-owners are never lost; they wait for rotation.
- Reset mid-packet: all state returns immediately to reset values. An in-flight `o_a` beat is discarded, and the partially sent packet is not resumed.

## Timing
- Arbitration: request high in cycle 0 with the arbiter idle → `o_gnt` high in cycle 1 → first beat accepted at the end of cycle 1 → `o_valid`=1 in cycle 2.
- Throughput: one beat per cycle while `i_ready`=1. A beat is accepted in the same cycle that `o_valid & i_ready` empties the register.
- Backpressure: with `i_ready`=0 and `o_valid`=1, no beat is accepted. The owner holds its data and `i_last` stable.
- Every release costs one IDLE cycle before the next grant; the grant-to-grant gap is at least 1 cycle.
- A request rising in the release cycle is seen in the following IDLE cycle.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined: releases on `i_last`, on drop, or after `MAX_HOLD` accepted beats, whichever comes first. A packet cut by the limit continues on the owner's next grant.
- `ARB_HOLD_LIMIT_EN` not defined: releases only on `i_last` or drop. `MAX_HOLD` and the beat counter have no effect on behaviour.

## Test plan
- **Reset then single requester:** `i_req`=4'b0100, data 8'hA5, `i_last`=1 → `o_gnt`=4'b0100 in cycle 1, `o_a`=8'hA5 with `o_valid`=1 in cycle 2, `o_gnt`=0 in cycle 2.
- **Rotation:** all four requesters request continuously, each beat `i_last`=1 → grant order 0,1,2,3,0, with one idle cycle between grants.
- **Backpressure:** owner sends 8'h11, 8'h22; `i_ready`=0 for 3 cycles after the first load → `o_a` stays 8'h11 and `o_valid`=1 for 3 cycles, then 8'h22 follows with no beat lost or duplicated.
- **Hold limit:** with `ARB_HOLD_LIMIT_EN` and `MAX_HOLD`=4, requester 1 sends a 6-beat packet while requester 2 waits → 4 beats, then requester 2 is granted, then requester 1 finishes its last 2 beats. Without the macro, all 6 beats go out contiguously.
- **Drop:** the owner deasserts `i_req` mid-packet → release in that cycle, no beat loaded, and the next requester is granted after the IDLE cycle.
- **Async reset mid-packet:** assert `i_rst_n`=0 between edges while `o_valid`=1 → `o_gnt`, `o_valid` and `o_a` go to 0 immediately, and the first grant after reset is the lowest requesting index.

Source files
------------

// File: rtl/shared_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// shared_bus_rr_arbiter
//
// Round-robin arbiter that shares one registered output beat register between
// N_REQ requesters. One owner is granted at a time. The owner's beats are
// loaded into a one-entry output register under a valid/ready handshake.
// Ownership rotates on packet end (i_last), on request drop, or, when the
// hold limit is compiled in, after MAX_HOLD accepted beats.
//
// Build option:
//   ARB_HOLD_LIMIT_EN  - when defined, a grant also ends after MAX_HOLD
//                        accepted beats. The rest of a cut packet goes out on
//                        the owner's next grant.
//
// Parameters:
//   N_REQ     number of requesters (2..8)
//   DATA_W    beat width
//   MAX_HOLD  beats per grant when the hold limit is built in (1..15)
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_req     per-requester request; bit k means a beat is on slice k
//   i_data    requester k beat on [k*DATA_W +: DATA_W]
//   i_last    requester k beat is the final beat of its packet
//   o_gnt     registered one-hot grant, zero when idle
//   i_ready   downstream takes o_a when o_valid & i_ready
//   o_valid   o_a holds an unconsumed beat
//   o_a       registered shared output beat
// -----------------------------------------------------------------------------
module shared_bus_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_data,
    input  logic [N_REQ-1:0]          i_last,
    output logic [N_REQ-1:0]          o_gnt,
    input  logic                      i_ready,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_a
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic HOLD_EN = 1'b1;
`else
    localparam logic HOLD_EN = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]        state_q,      state_d;
    logic [N_REQ-1:0]  gnt_q,        gnt_d;
    logic [IDX_W-1:0]  owner_q,      owner_d;
    logic [IDX_W-1:0]  last_owner_q, last_owner_d;
    logic [3:0]        cnt_q,        cnt_d;
    logic              valid_q,      valid_d;
    logic [DATA_W-1:0] a_q,          a_d;

    // -------------------------------------------------------------------------
    // Round-robin pick: first requester scanning upward from last_owner+1.
    // The scan ends at last_owner itself, so a lone requester may be
    // granted again after its own release.
    // -------------------------------------------------------------------------
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    int               cand;

    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first; a path that skips an assignment would otherwise infer a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_owner_q) + i) % N_REQ;
            if (!pick_found && i_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Owner view and beat counter
    // -------------------------------------------------------------------------
    logic              own_req;
    logic              own_last;
    logic [DATA_W-1:0] own_data;
    logic [3:0]        cnt_inc;
    logic              hold_hit;

    assign own_req  = i_req[owner_q];
    assign own_last = i_last[owner_q];
    assign own_data = i_data[int'(owner_q)*DATA_W +: DATA_W];
    assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    // cnt_inc is the count including the beat accepted this cycle.
    assign hold_hit = (cnt_inc == 4'(MAX_HOLD));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic accept;
    logic release_gnt;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        a_d          = a_q;
        accept       = 1'b0;
        release_gnt  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                gnt_d   = N_REQ'(1) << pick_idx;
                owner_d = pick_idx;
                cnt_d   = 4'd0;
                state_d = ST_BUSY;
            end
        end else begin
            // The register can take a beat when empty or when it is being
            // emptied by downstream in this same cycle.
            accept = own_req & (~valid_q | i_ready);
            if (!own_req) begin
                release_gnt = 1'b1;
            end else if (accept) begin
                cnt_d       = cnt_inc;
                release_gnt = own_last | (HOLD_EN & hold_hit);
            end
            if (release_gnt) begin
                state_d      = ST_IDLE;
                gnt_d        = '0;
                last_owner_d = owner_q;
            end
        end

        if (accept) begin
            a_d     = own_data;
            valid_d = 1'b1;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            cnt_q        <= 4'd0;
            valid_q      <= 1'b0;
            a_q          <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            a_q          <= a_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_valid = valid_q;
    assign o_a     = a_q;

endmodule

// File: tb/tb_shared_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for shared_bus_rr_arbiter (N_REQ=4, DATA_W=8, MAX_HOLD=4).
// Each requester is fed from a packet queue. Expected output beats and the
// expected grant order are queued up front for each scenario. They are popped
// as the DUT hands beats downstream or raises a new grant.
// -----------------------------------------------------------------------------
module tb_shared_bus_rr_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int HOLD = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [N-1:0]     i_req;
    logic [N*W-1:0]   i_data;
    logic [N-1:0]     i_last;
    logic [N-1:0]     o_gnt;
    logic             i_ready;
    logic             o_valid;
    logic [W-1:0]     o_a;

    shared_bus_rr_arbiter #(
        .N_REQ    (N),
        .DATA_W   (W),
        .MAX_HOLD (HOLD)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_gnt   (o_gnt),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_a     (o_a)
    );

    always #5 i_clk = ~i_clk;

    // Per-requester packet queues: {last, data}.
    logic [8:0]   pkt_q [N][$];
    logic [7:0]   exp_data [$];
    logic [N-1:0] exp_gnt [$];
    int           acc_cnt [N];
    int           drop_at [N];
    logic [N-1:0] mask;
    logic [N-1:0] prev_gnt;
    int           n_vec;
    int           n_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int k, input logic [7:0] d, input logic l);
        pkt_q[k].push_back({l, d});
    endtask

    task automatic drive_reqs();
        logic [8:0] b;
        for (int k = 0; k < N; k++) begin
            if (pkt_q[k].size() > 0 && !mask[k]) begin
                b = pkt_q[k][0];
                i_req[k]        = 1'b1;
                i_data[k*W +: W] = b[7:0];
                i_last[k]       = b[8];
            end else begin
                i_req[k]        = 1'b0;
                i_data[k*W +: W] = '0;
                i_last[k]       = 1'b0;
            end
        end
    endtask

    function automatic int pending();
        int p;
        p = exp_data.size() + exp_gnt.size() + int'(o_valid) + int'(o_gnt != '0);
        for (int k = 0; k < N; k++) p += pkt_q[k].size();
        return p;
    endfunction

    // One clock cycle: observe at the falling edge, update requesters and
    // drive new inputs just after the rising edge.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge i_clk);
        acc = '0;
        for (int k = 0; k < N; k++)
            if (o_gnt[k] && i_req[k] && (!o_valid || i_ready)) acc[k] = 1'b1;
        if (o_valid && i_ready) begin
            if (exp_data.size() == 0) check("sb_extra_beat", exp_data.size(), 1);
            else                      check("beat", o_a, exp_data.pop_front());
        end
        if (o_gnt != '0 && o_gnt != prev_gnt) begin
            check("gnt_gap", prev_gnt, 0);
            if (exp_gnt.size() == 0) check("gnt_extra", exp_gnt.size(), 1);
            else                     check("gnt_order", o_gnt, exp_gnt.pop_front());
        end
        prev_gnt = o_gnt;
        @(posedge i_clk);
        #1;
        mask = '0;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                void'(pkt_q[k].pop_front());
                acc_cnt[k]++;
                if (drop_at[k] >= 0 && acc_cnt[k] == drop_at[k]) begin
                    mask[k]    = 1'b1;
                    drop_at[k] = -1;
                end
            end
        end
        drive_reqs();
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (pending() > 0 && guard < 300) begin
            step();
            guard++;
        end
        check(tag, pending(), 0);
    endtask

    task automatic wait_valid(input string tag);
        int guard;
        guard = 0;
        while (!o_valid && guard < 20) begin
            step();
            guard++;
        end
        check(tag, o_valid, 1);
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            pkt_q[k].delete();
            acc_cnt[k] = 0;
            drop_at[k] = -1;
        end
        exp_data.delete();
        exp_gnt.delete();
        mask     = '0;
        prev_gnt = '0;
        i_ready  = 1'b1;
        drive_reqs();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        i_req   = '0;
        i_data  = '0;
        i_last  = '0;
        i_ready = 1'b1;
        apply_reset();

        // Reset values
        check("rst_gnt",   o_gnt,   0);
        check("rst_valid", o_valid, 0);
        check("rst_a",     o_a,     0);

        // Single requester: grant in cycle 1, beat visible in cycle 2
        push_pkt(2, 8'hA5, 1'b1);
        exp_data.push_back(8'hA5);
        exp_gnt.push_back(4'b0100);
        drive_reqs();
        step();
        check("single_gnt_c1",   o_gnt,   4'b0100);
        check("single_valid_c1", o_valid, 0);
        step();
        check("single_a_c2",     o_a,     8'hA5);
        check("single_valid_c2", o_valid, 1);
        check("single_gnt_c2",   o_gnt,   0);
        drain("single_drain");

        // Rotation: four requesters, single-beat packets, two rounds
        apply_reset();
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < N; k++) begin
                push_pkt(k, 8'(k * 16 + n), 1'b1);
                exp_data.push_back(8'(k * 16 + n));
                exp_gnt.push_back(4'(1 << k));
            end
        end
        drive_reqs();
        drain("rot_drain");

        // Backpressure: first beat held for three stalled cycles
        push_pkt(1, 8'h11, 1'b0);
        push_pkt(1, 8'h22, 1'b1);
        exp_data.push_back(8'h11);
        exp_data.push_back(8'h22);
        exp_gnt.push_back(4'b0010);
        drive_reqs();
        wait_valid("bp_load");
        check("bp_first_a", o_a, 8'h11);
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_a",     o_a,     8'h11);
            check("bp_hold_valid", o_valid, 1);
            check("bp_hold_gnt",   o_gnt,   4'b0010);
            step();
        end
        i_ready = 1'b1;
        drain("bp_drain");

        // Hold limit: 6-beat packet on requester 1, requester 2 waiting
        apply_reset();
        for (int b = 1; b <= 6; b++) push_pkt(1, 8'(8'h60 + b), (b == 6));
        push_pkt(2, 8'h2A, 1'b1);
`ifdef ARB_HOLD_LIMIT_EN
        for (int b = 1; b <= 4; b++) exp_data.push_back(8'(8'h60 + b));
        exp_data.push_back(8'h2A);
        exp_data.push_back(8'h65);
        exp_data.push_back(8'h66);
        exp_gnt.push_back(4'b0010);
        exp_gnt.push_back(4'b0100);
        exp_gnt.push_back(4'b0010);
`else
        for (int b = 1; b <= 6; b++) exp_data.push_back(8'(8'h60 + b));
        exp_data.push_back(8'h2A);
        exp_gnt.push_back(4'b0010);
        exp_gnt.push_back(4'b0100);
`endif
        drive_reqs();
        drain("hold_drain");

        // Drop: requester 0 lowers its request after two beats
        apply_reset();
        push_pkt(0, 8'h01, 1'b0);
        push_pkt(0, 8'h02, 1'b0);
        push_pkt(0, 8'h03, 1'b1);
        push_pkt(2, 8'h2B, 1'b1);
        drop_at[0] = 2;
        exp_data.push_back(8'h01);
        exp_data.push_back(8'h02);
        exp_data.push_back(8'h2B);
        exp_data.push_back(8'h03);
        exp_gnt.push_back(4'b0001);
        exp_gnt.push_back(4'b0100);
        exp_gnt.push_back(4'b0001);
        drive_reqs();
        drain("drop_drain");

        // Asynchronous reset between edges while a beat is pending
        push_pkt(2, 8'hC1, 1'b0);
        push_pkt(2, 8'hC2, 1'b0);
        push_pkt(2, 8'hC3, 1'b1);
        exp_gnt.push_back(4'b0100);
        drive_reqs();
        wait_valid("arst_load");
        #3;
        i_rst_n = 1'b0;
        #1;
        check("arst_gnt",   o_gnt,   0);
        check("arst_valid", o_valid, 0);
        check("arst_a",     o_a,     0);
        apply_reset();
        push_pkt(1, 8'h1D, 1'b1);
        push_pkt(3, 8'h3D, 1'b1);
        exp_data.push_back(8'h1D);
        exp_data.push_back(8'h3D);
        exp_gnt.push_back(4'b0010);
        exp_gnt.push_back(4'b1000);
        drive_reqs();
        drain("arst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
